sram_arbiter2: RTL
==================

# sram_arbiter2

Two-port arbiter and sequencer for the board's external asynchronous 16-bit SRAM (20-bit address, active-low CE/OE/WE/UB/LB). It shares the single SRAM between two internal requesters through a req/ack handshake, runs one complete read or write cycle per grant, and owns every SRAM pin. It sits between the user logic (switch/LED test logic, future DMA or video clients) and the SRAM pads.

## Interface
- `WAIT_CYC`, 2: cycles the CE plus OE/WE strobe stays asserted; must be ≥1.
- `clock_50mhz` in 1: system clock; all logic on the rising edge.
- `pinReset` in 1: asynchronous, active-low reset.
- `req0` / `req1` in 1: transaction request from port 0 / port 1. Held until ack.
- `we0` / `we1` in 1: 1 = write, 0 = read.
- `addr0` / `addr1` in 20: word address.
- `wdata0` / `wdata1` in 16: write data.
- `be0` / `be1` in 2: byte enables; bit1 = upper byte (UB), bit0 = lower byte (LB).
- `ack0` / `ack1` out 1: one-cycle completion pulse.
- `rdata0` / `rdata1` out 16: read data. Valid with ack; held until the next read on that port.
- `busy` out 1: high in every state except IDLE.
- `pinAddr` out 20: SRAM address.
- `pinData` inout 16: SRAM data. Driven only during writes; Z otherwise.
- `pinCE`, `pinOE`, `pinWE`, `pinUB`, `pinLB` out 1 each: SRAM controls, active-low.

## Operation
- **FSM states:** IDLE → SETUP → ACCESS → RECOVER → IDLE.
- **IDLE:** sample req0/req1. On any request, grant one port, latch its we/addr/wdata/be into internal registers, and go to SETUP.
- **SETUP:** pinAddr = latched address; all strobes high. For a write, pinData drives wdata from this cycle on.
- **ACCESS (WAIT_CYC cycles, tracked by a down-counter):**
  - pinCE = 0.
  - pinWE = 0 for a write; pinOE = 0 for a read.
  - pinUB = ~be[1]; pinLB = ~be[0].
  - Read: pinData is captured on the clock edge that leaves ACCESS. Disabled bytes are zeroed in rdata.
- **RECOVER:**
  - All strobes high; pinAddr and write data are still held (hold time).
  - ack of the granted port = 1; rdata updates on the same edge for reads.
  - Next state is always IDLE, so back-to-back grants are separated by one idle cycle.
- **be = 00:** same sequence and timing, but CE/OE/WE stay high. ack still pulses; for reads, rdata = 0.
- **Handshake:** the requester keeps req and its fields stable until it samples ack = 1, then drops req on that edge. A req still high in IDLE is treated as a new request.
- **Arbitration:** fixed priority, port 0 over port 1 (see Configuration). The grant is made only in IDLE and is never preempted.
- **Reset (including mid-transaction):**
  - pinCE/OE/WE/UB/LB = 1, pinAddr = 0, pinData = Z.
  - ack0/ack1 = 0, rdata0/rdata1 = 0, busy = 0, FSM = IDLE.
  - Any in-flight transaction is dropped with no ack.

## Timing
- Request sampled in IDLE at edge N:
  - SETUP in cycle N+1.
  - ACCESS in cycles N+2 … N+1+WAIT_CYC.
  - ack high in cycle N+2+WAIT_CYC (4 cycles after sampling at WAIT_CYC = 2).
- Throughput: one transaction per WAIT_CYC+3 cycles.
- Strobes, address and data-enable are registered outputs (no glitches). Address is stable for one cycle before and one cycle after the strobes.

## Configuration
- `SRAM_ARB_RR_EN` defined: round-robin arbitration.
  - A 1-bit last-grant register, reset to 1, so port 0 wins the first tie.
  - On simultaneous requests the port not granted last wins.
  - A lone requester is always granted.
- Not defined: fixed priority, port 0 always wins ties; no last-grant register.

## Test plan
- Write then read, port 0: write addr 0x0000A, wdata 0x1234, be 11; then read addr 0x0000A. Required:
  - ack0 pulses 4 cycles after each req is sampled.
  - rdata0 = 0x1234.
  - pinWE low for exactly 2 cycles; pinOE stays high during the write.
- Byte write: write 0xFFFF to addr 0x0000B, then write 0xAB00 with be 10, then read with be 11. Required: pinLB high during the byte write; rdata = 0xABFF.
- Simultaneous requests, both ports held high for 4 transactions:
  - Without the macro: acks go 0, 0, 0, 0 while req0 stays high.
  - With `SRAM_ARB_RR_EN`: acks alternate 0, 1, 0, 1.
- be = 00 read on port 1. Required: no CE/OE assertion, ack1 pulses, rdata1 = 0.
- Reset mid-transaction: assert pinReset in the second ACCESS cycle of a write. Required:
  - All strobes high and pinData = Z within the same cycle, asynchronously.
  - No ack.
  - busy = 0 after release; the next request completes normally.

Source files
------------

// File: rtl/sram_arbiter2.sv
// rtl/sram_arbiter2.sv - two-port req/ack arbiter and cycle sequencer for an async 16-bit SRAM
// Optional feature: define SRAM_ARB_RR_EN for round-robin arbitration (default: fixed priority, port 0 first).
module sram_arbiter2 #(
   parameter int WAIT_CYC = 2
) (
   input  logic        clock_50mhz,
   input  logic        pinReset,
   input  logic        req0,
   input  logic        req1,
   input  logic        we0,
   input  logic        we1,
   input  logic [19:0] addr0,
   input  logic [19:0] addr1,
   input  logic [15:0] wdata0,
   input  logic [15:0] wdata1,
   input  logic [1:0]  be0,
   input  logic [1:0]  be1,
   output logic        ack0,
   output logic        ack1,
   output logic [15:0] rdata0,
   output logic [15:0] rdata1,
   output logic        busy,
   output logic [19:0] pinAddr,
   inout  wire  [15:0] pinData,
   output logic        pinCE,
   output logic        pinOE,
   output logic        pinWE,
   output logic        pinUB,
   output logic        pinLB
);

   localparam int CW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETUP   = 2'd1,
      ST_ACCESS  = 2'd2,
      ST_RECOVER = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic          gnt_q, gnt_d;
   logic          we_q, we_d;
   logic [19:0]   addr_q, addr_d;
   logic [15:0]   wdata_q, wdata_d;
   logic [1:0]    be_q, be_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ce_q, ce_d;
   logic          oe_q, oe_d;
   logic          wr_q, wr_d;
   logic          ub_q, ub_d;
   logic          lb_q, lb_d;
   logic          data_oe_q, data_oe_d;
   logic          ack0_q, ack0_d;
   logic          ack1_q, ack1_d;
   logic [15:0]   rdata0_q, rdata0_d;
   logic [15:0]   rdata1_q, rdata1_d;
   logic          pick1;
   logic          strobe_en;
   logic [15:0]   rd_masked;
`ifdef SRAM_ARB_RR_EN
   logic          last_q, last_d;
`endif

   // Choose which port wins when leaving IDLE
   always_comb begin
      pick1 = 1'b0;
`ifdef SRAM_ARB_RR_EN
      if (req0 && req1) begin
         pick1 = ~last_q;
      end else begin
         pick1 = req1;
      end
`else
      pick1 = ~req0;
`endif
   end

   // Disabled byte lanes read back as zero; be = 00 suppresses the chip strobes entirely
   always_comb begin
      strobe_en = |be_q;
      rd_masked = pinData & {{8{be_q[1]}}, {8{be_q[0]}}};
   end

   // Next-state and registered-output logic for the SETUP/ACCESS/RECOVER sequence
   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      be_d      = be_q;
      cnt_d     = cnt_q;
      ce_d      = ce_q;
      oe_d      = oe_q;
      wr_d      = wr_q;
      ub_d      = ub_q;
      lb_d      = lb_q;
      data_oe_d = data_oe_q;
      ack0_d    = 1'b0;
      ack1_d    = 1'b0;
      rdata0_d  = rdata0_q;
      rdata1_d  = rdata1_q;
`ifdef SRAM_ARB_RR_EN
      last_d    = last_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (req0 || req1) begin
               state_d   = ST_SETUP;
               gnt_d     = pick1;
               we_d      = pick1 ? we1    : we0;
               addr_d    = pick1 ? addr1  : addr0;
               wdata_d   = pick1 ? wdata1 : wdata0;
               be_d      = pick1 ? be1    : be0;
               data_oe_d = pick1 ? we1    : we0;
`ifdef SRAM_ARB_RR_EN
               last_d    = pick1;
`endif
            end
         end
         ST_SETUP: begin
            state_d = ST_ACCESS;
            cnt_d   = CW'(WAIT_CYC - 1);
            ce_d    = ~strobe_en;
            oe_d    = ~(strobe_en & ~we_q);
            wr_d    = ~(strobe_en & we_q);
            ub_d    = ~be_q[1];
            lb_d    = ~be_q[0];
         end
         ST_ACCESS: begin
            if (cnt_q == '0) begin
               state_d = ST_RECOVER;
               ce_d    = 1'b1;
               oe_d    = 1'b1;
               wr_d    = 1'b1;
               ub_d    = 1'b1;
               lb_d    = 1'b1;
               ack0_d  = ~gnt_q;
               ack1_d  = gnt_q;
               if (!we_q) begin
                  if (gnt_q) begin
                     rdata1_d = rd_masked;
                  end else begin
                     rdata0_d = rd_masked;
                  end
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_RECOVER: begin
            state_d   = ST_IDLE;
            data_oe_d = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset drops any in-flight cycle and releases the bus
   always_ff @(posedge clock_50mhz or negedge pinReset) begin
      if (!pinReset) begin
         state_q   <= ST_IDLE;
         gnt_q     <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         be_q      <= '0;
         cnt_q     <= '0;
         ce_q      <= 1'b1;
         oe_q      <= 1'b1;
         wr_q      <= 1'b1;
         ub_q      <= 1'b1;
         lb_q      <= 1'b1;
         data_oe_q <= 1'b0;
         ack0_q    <= 1'b0;
         ack1_q    <= 1'b0;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
`ifdef SRAM_ARB_RR_EN
         last_q    <= 1'b1;
`endif
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         be_q      <= be_d;
         cnt_q     <= cnt_d;
         ce_q      <= ce_d;
         oe_q      <= oe_d;
         wr_q      <= wr_d;
         ub_q      <= ub_d;
         lb_q      <= lb_d;
         data_oe_q <= data_oe_d;
         ack0_q    <= ack0_d;
         ack1_q    <= ack1_d;
         rdata0_q  <= rdata0_d;
         rdata1_q  <= rdata1_d;
`ifdef SRAM_ARB_RR_EN
         last_q    <= last_d;
`endif
      end
   end

   assign pinData = data_oe_q ? wdata_q : 16'bz;
   assign pinAddr = addr_q;
   assign pinCE   = ce_q;
   assign pinOE   = oe_q;
   assign pinWE   = wr_q;
   assign pinUB   = ub_q;
   assign pinLB   = lb_q;
   assign ack0    = ack0_q;
   assign ack1    = ack1_q;
   assign rdata0  = rdata0_q;
   assign rdata1  = rdata1_q;
   assign busy    = (state_q != ST_IDLE);

endmodule
